// File: rtl/meas_seq_ctrl.sv
// Gated-measurement sequencer: snapshots cnt_in across a fixed gate, then shifts out {SYNC, result}
// on a self-generated bit clock. Define MEAS_PARITY_EN to append an even-parity bit after the result.
module meas_seq_ctrl #(
  parameter int unsigned WIDTH       = 31,
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned BIT_DIV     = 25,
  parameter logic [7:0]  SYNC        = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             bit_clk,
  output logic             ser_out,
  output logic             frame_active
);

`ifdef MEAS_PARITY_EN
  localparam int unsigned FB = WIDTH + 9;
`else
  localparam int unsigned FB = WIDTH + 8;
`endif
  localparam int unsigned TW = $clog2(GATE_CYCLES);
  localparam int unsigned DW = $clog2(2 * BIT_DIV);
  localparam int unsigned BW = $clog2(FB);

  localparam logic [TW-1:0] GATE_INIT = TW'(GATE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * BIT_DIV - 1);
  localparam logic [DW-1:0] DIV_HIGH  = DW'(BIT_DIV);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FB - 1);

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_CAPTURE, S_SHIFT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_done;
  logic [TW-1:0]    r_timer;
  logic [DW-1:0]    r_div;
  logic [BW-1:0]    r_bit;
  logic [FB-1:0]    r_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_bit_end;
  logic             w_frame_end;

  assign w_diff      = cnt_in - r_start;
  assign w_bit_end   = (r_div == DIV_LAST);
  assign w_frame_end = w_bit_end && (r_bit == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Leaving GATE on the edge that takes the timer to 0 puts the CAPTURE edge at start edge + GATE_CYCLES.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_GATE;
      S_GATE:    if (r_timer == TW'(1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SHIFT;
      S_SHIFT:   if (w_frame_end) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_timer  <= '0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sh     <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_start <= cnt_in;
            r_timer <= GATE_INIT;
            r_valid <= 1'b0;
          end
        end
        S_GATE: r_timer <= r_timer - TW'(1);
        S_CAPTURE: begin
          r_result <= w_diff;
          r_valid  <= 1'b1;
`ifdef MEAS_PARITY_EN
          r_sh     <= {SYNC, w_diff, ^w_diff};
`else
          r_sh     <= {SYNC, w_diff};
`endif
          r_div    <= '0;
          r_bit    <= '0;
        end
        S_SHIFT: begin
          if (w_bit_end) begin
            r_div  <= '0;
            r_bit  <= r_bit + BW'(1);
            r_sh   <= {r_sh[FB-2:0], 1'b1};
            r_done <= w_frame_end;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Frame bit changes only when r_div wraps, i.e. at the start of a low phase.
  always_comb begin
    busy         = (r_state != S_IDLE);
    frame_active = (r_state == S_SHIFT);
    bit_clk      = (r_state == S_SHIFT) && (r_div >= DIV_HIGH);
    ser_out      = (r_state == S_SHIFT) ? r_sh[FB-1] : 1'b1;
    done         = r_done;
    result       = r_result;
    result_valid = r_valid;
  end

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Self-checking bench for meas_seq_ctrl (WIDTH=12, GATE_CYCLES=10, BIT_DIV=2): table vectors,
// randomized measurements against a snapshot-difference model, and reset/re-start corner cases.
module tb_meas_seq_ctrl;
  localparam int W  = 12;
  localparam int G  = 10;
  localparam int BD = 2;
`ifdef MEAS_PARITY_EN
  localparam int FB = W + 9;
`else
  localparam int FB = W + 8;
`endif
  localparam int FRAME_CYC = 2 * BD * FB;

  logic         clk;
  logic         reset;
  logic [W-1:0] cnt_in;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         result_valid;
  logic         bit_clk;
  logic         ser_out;
  logic         frame_active;

  logic [W-1:0] inc_g;
  int           n_cmp;
  int           n_bad;

  meas_seq_ctrl #(.WIDTH(W), .GATE_CYCLES(G), .BIT_DIV(BD), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .start(start), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid), .bit_clk(bit_clk), .ser_out(ser_out),
    .frame_active(frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] inc;
    logic [W-1:0] exp_res;
    bit           pulses;
    bit           hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counter advances once per clk, as the free-running source would.
  task automatic tick();
    @(posedge clk);
    #1;
    cnt_in = cnt_in + inc_g;
  endtask

  task automatic run_meas(input logic [W-1:0] base, input logic [W-1:0] inc,
                          input logic [W-1:0] exp_res, input bit use_exp,
                          input bit pulses, input bit hold);
    logic [W-1:0] v0, vg, model, want;
    logic [63:0]  bits, frame;
    logic         prev_bclk, prev_ser;
    int           shift_n, done_n, nbits, busy_bad, stab_bad, extra_done;
    inc_g  = inc;
    cnt_in = base;
    start  = 1'b1;
    v0     = cnt_in;
    vg     = '0;
    model  = '0;
    tick();
    if (!hold) start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("valid_cleared", 64'(result_valid), 64'(0));
    shift_n = -1; done_n = -1; nbits = 0; busy_bad = 0; stab_bad = 0;
    bits = '0;
    prev_bclk = bit_clk;
    prev_ser  = ser_out;
    for (int n = 1; n <= G + FRAME_CYC + 20 && done_n < 0; n++) begin
      if (n == G) vg = cnt_in;
      if (pulses) start = (n == 3 || n == G + 20);
      tick();
      if (n == G - 1) chk("valid_before_capture", 64'(result_valid), 64'(0));
      if (n == G) begin
        model = vg - v0;
        chk("result", 64'(result), 64'(use_exp ? exp_res : model));
        chk("result_valid", 64'(result_valid), 64'(1));
      end
      if (frame_active && shift_n < 0) shift_n = n;
      if (bit_clk && !prev_bclk) begin
        bits = {bits[62:0], ser_out};
        nbits++;
        if (ser_out !== prev_ser) stab_bad++;
      end
      if (done) done_n = n;
      else if (!busy) busy_bad++;
      prev_bclk = bit_clk;
      prev_ser  = ser_out;
    end
    if (pulses) start = 1'b0;
    want  = use_exp ? exp_res : model;
    frame = '0;
`ifdef MEAS_PARITY_EN
    frame[FB-1:0] = {8'hA5, want, ^want};
`else
    frame[FB-1:0] = {8'hA5, want};
`endif
    chk("done_seen", 64'(done_n >= 0), 64'(1));
    chk("shift_start", 64'(shift_n), 64'(G));
    chk("frame_len", 64'(done_n - shift_n), 64'(FRAME_CYC));
    chk("bit_count", 64'(nbits), 64'(FB));
    chk("frame_bits", bits, frame);
    chk("ser_stable_at_rise", 64'(stab_bad), 64'(0));
    chk("busy_during_meas", 64'(busy_bad), 64'(0));
    chk("done_bit_clk", 64'(bit_clk), 64'(0));
    chk("done_ser_out", 64'(ser_out), 64'(1));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_frame_active", 64'(frame_active), 64'(0));
    if (hold) begin
      tick();
      chk("hold_restart_busy", 64'(busy), 64'(1));
      chk("hold_restart_valid", 64'(result_valid), 64'(0));
      start = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end else begin
      extra_done = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (done || busy) extra_done++;
      end
      chk("idle_after_done", 64'(extra_done), 64'(0));
      chk("result_persists", 64'(result), 64'(want));
      chk("valid_persists", 64'(result_valid), 64'(1));
    end
  endtask

  task automatic reset_mid_shift();
    int ndone;
    inc_g  = 12'd3;
    cnt_in = 12'h100;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < G + 15; k++) tick();
    chk("rst_pre_frame_active", 64'(frame_active), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_bit_clk", 64'(bit_clk), 64'(0));
    chk("rst_ser_out", 64'(ser_out), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(result_valid), 64'(0));
    chk("rst_frame_active", 64'(frame_active), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    ndone = 0;
    for (int k = 0; k < FRAME_CYC + 10; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("rst_no_done", 64'(ndone), 64'(0));
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    cnt_in = '0;
    inc_g  = 12'd1;

    tbl[0] = '{base: 12'h100, inc: 12'd3,   exp_res: 12'h01E, pulses: 1'b0, hold: 1'b0};
    tbl[1] = '{base: 12'hFF0, inc: 12'd3,   exp_res: 12'h01E, pulses: 1'b0, hold: 1'b0};
    tbl[2] = '{base: 12'h000, inc: 12'd7,   exp_res: 12'h046, pulses: 1'b0, hold: 1'b0};
    tbl[3] = '{base: 12'hFFF, inc: 12'h400, exp_res: 12'h800, pulses: 1'b0, hold: 1'b0};
    tbl[4] = '{base: 12'h100, inc: 12'd3,   exp_res: 12'h01E, pulses: 1'b1, hold: 1'b0};
    tbl[5] = '{base: 12'h123, inc: 12'd5,   exp_res: 12'h032, pulses: 1'b0, hold: 1'b1};

    for (int k = 0; k < 3; k++) tick();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_valid", 64'(result_valid), 64'(0));
    chk("reset_bit_clk", 64'(bit_clk), 64'(0));
    chk("reset_ser_out", 64'(ser_out), 64'(1));
    chk("reset_frame_active", 64'(frame_active), 64'(0));

    reset_mid_shift();

    for (int i = 0; i < 6; i++)
      run_meas(tbl[i].base, tbl[i].inc, tbl[i].exp_res, 1'b1, tbl[i].pulses, tbl[i].hold);

    for (int i = 0; i < 6; i++)
      run_meas(12'($urandom), 12'($urandom_range(1, 4095)), 12'h000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
